// File: rtl/blink_queue.sv
// Turns single-cycle event pulses into fixed-shape LED blinks, queueing events that
// arrive mid-blink in a saturating pending counter and replaying them in order.
module blink_queue #(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned ON_TIME_MS  = 100,
  parameter int unsigned OFF_TIME_MS = 100,
  parameter int unsigned PEND_BITS   = 4
) (
  input  logic                 clk,
  input  logic                 rst_a_n,
  input  logic                 pulse_in,
  output logic                 led_out,
  output logic                 busy,
  output logic [PEND_BITS-1:0] pending,
  output logic                 overflow
);

  // 64-bit intermediates: CLK_FREQ * ms easily exceeds 32 bits at real clock rates
  localparam longint unsigned OnCyclesL  = 64'(CLK_FREQ) * 64'(ON_TIME_MS) / 64'd1000;
  localparam longint unsigned OffCyclesL = 64'(CLK_FREQ) * 64'(OFF_TIME_MS) / 64'd1000;
  localparam int unsigned OnCycles  = 32'(OnCyclesL);
  localparam int unsigned OffCycles = 32'(OffCyclesL);
  localparam int unsigned MaxCycles = (OnCycles > OffCycles) ? OnCycles : OffCycles;
  localparam int unsigned TimerW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [TimerW-1:0]    OnLoad  = TimerW'(OnCycles - 1);
  localparam logic [TimerW-1:0]    OffLoad = TimerW'(OffCycles - 1);
  localparam logic [PEND_BITS-1:0] PendMax = '1;

  typedef enum logic [1:0] {
    StIdle,
    StOn,
    StOff
  } state_e;

  state_e               r_state;
  logic [TimerW-1:0]    r_timer;
  logic [PEND_BITS-1:0] r_pending;
  logic                 r_led;
  logic                 r_busy;
  logic                 r_overflow;

  state_e               w_state_nxt;
  logic [TimerW-1:0]    w_timer_nxt;
  logic [PEND_BITS-1:0] w_pending_nxt;
  logic                 w_overflow_nxt;
  logic                 w_enqueue;

  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_pending_nxt  = r_pending;
    w_overflow_nxt = 1'b0;
    w_enqueue      = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (pulse_in) begin
          w_state_nxt = StOn;
          w_timer_nxt = OnLoad;
        end
      end
      StOn: begin
        w_enqueue = pulse_in;
        if (r_timer != '0) begin
          w_timer_nxt = r_timer - TimerW'(1);
        end else begin
          w_state_nxt = StOff;
          w_timer_nxt = OffLoad;
        end
      end
      StOff: begin
        if (r_timer != '0) begin
          w_timer_nxt = r_timer - TimerW'(1);
          w_enqueue   = pulse_in;
        end else if (r_pending != '0) begin
          // A coincident pulse replaces the dequeued event, so the count holds
          w_state_nxt = StOn;
          w_timer_nxt = OnLoad;
          if (!pulse_in) w_pending_nxt = r_pending - PEND_BITS'(1);
        end else if (pulse_in) begin
          w_state_nxt = StOn;
          w_timer_nxt = OnLoad;
        end else begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase

    if (w_enqueue) begin
      if (r_pending == PendMax) w_overflow_nxt = 1'b1;
      else                      w_pending_nxt  = r_pending + PEND_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      r_state    <= StIdle;
      r_timer    <= '0;
      r_pending  <= '0;
      r_led      <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_pending  <= w_pending_nxt;
      r_led      <= (w_state_nxt == StOn);
      r_busy     <= (w_state_nxt != StIdle);
      r_overflow <= w_overflow_nxt;
    end
  end

  assign led_out  = r_led;
  assign busy     = r_busy;
  assign pending  = r_pending;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_blink_queue.sv
// Scoreboard bench for blink_queue: stimulus queues expected blink-start and overflow
// cycles, a negedge monitor pops and compares them as the DUT produces them.
module tb_blink_queue;

  logic       clk = 1'b0;
  logic       rst_a_n;
  logic       pulse_in;
  logic       led_out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_rise[$];
  int exp_ovf[$];

  blink_queue #(
    .CLK_FREQ   (1000),
    .ON_TIME_MS (4),
    .OFF_TIME_MS(2),
    .PEND_BITS  (2)
  ) dut (
    .clk     (clk),
    .rst_a_n (rst_a_n),
    .pulse_in(pulse_in),
    .led_out (led_out),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: blink starts and overflow pulses are matched against the scoreboard
  initial begin
    logic prev_led;
    int   hi_len;
    prev_led = 1'b0;
    hi_len   = 0;
    forever begin
      @(negedge clk);
      if (!rst_a_n) begin
        prev_led = 1'b0;
        hi_len   = 0;
      end else begin
        if (led_out && !prev_led) begin
          if (exp_rise.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rise_unexpected: blink started at cycle %0d, none expected", cyc);
          end else begin
            chk("rise_cycle", cyc, exp_rise.pop_front());
          end
        end
        if (led_out) begin
          hi_len++;
        end else if (prev_led) begin
          chk("on_width", hi_len, 4);
          hi_len = 0;
        end
        if (overflow) begin
          if (exp_ovf.size() == 0) begin
            total++;
            bad++;
            $display("FAIL ovf_unexpected: overflow at cycle %0d, none expected", cyc);
          end else begin
            chk("ovf_cycle", cyc, exp_ovf.pop_front());
          end
        end
        prev_led = led_out;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step(input logic p);
    pulse_in = p;
    @(negedge clk);
  endtask

  task automatic idle_until(input int target);
    while (cyc < target) step(1'b0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step(1'b0);
      n++;
    end
    chk("idle_reached", int'(busy), 0);
  endtask

  initial begin
    int base;
    rst_a_n  = 1'b0;
    pulse_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_led", int'(led_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_overflow", int'(overflow), 0);
    rst_a_n = 1'b1;
    repeat (2) step(1'b0);

    // Single pulse: 4 on, 2 off, busy for 6
    base = cyc;
    exp_rise.push_back(base + 1);
    step(1'b1);
    for (int i = 0; i < 6; i++) begin
      chk("s1_busy", int'(busy), 1);
      chk("s1_led", int'(led_out), int'(i < 4));
      chk("s1_pending", int'(pending), 0);
      step(1'b0);
    end
    chk("s1_idle", int'(busy), 0);
    repeat (2) step(1'b0);

    // Queued pulses at t=0,1,3
    base = cyc;
    exp_rise.push_back(base + 1);
    exp_rise.push_back(base + 7);
    exp_rise.push_back(base + 13);
    step(1'b1);
    chk("s2_pend_t1", int'(pending), 0);
    step(1'b1);
    chk("s2_pend_t2", int'(pending), 1);
    step(1'b0);
    chk("s2_pend_t3", int'(pending), 1);
    step(1'b1);
    chk("s2_pend_t4", int'(pending), 2);
    idle_until(base + 6);
    chk("s2_pend_t6", int'(pending), 2);
    step(1'b0);
    chk("s2_pend_t7", int'(pending), 1);
    idle_until(base + 12);
    chk("s2_pend_t12", int'(pending), 1);
    step(1'b0);
    chk("s2_pend_t13", int'(pending), 0);
    wait_idle(20);
    chk("s2_end_cycle", cyc, base + 19);
    repeat (2) step(1'b0);

    // Saturation: pulse held 6 cycles
    base = cyc;
    for (int i = 0; i < 4; i++) exp_rise.push_back(base + 1 + 6 * i);
    exp_ovf.push_back(base + 5);
    exp_ovf.push_back(base + 6);
    repeat (6) step(1'b1);
    chk("s3_pend_sat", int'(pending), 3);
    step(1'b0);
    chk("s3_pend_deq", int'(pending), 2);
    chk("s3_ovf_clear", int'(overflow), 0);
    wait_idle(40);
    chk("s3_end_cycle", cyc, base + 25);
    repeat (2) step(1'b0);

    // Simultaneous enqueue/dequeue at PEND_MAX on the OFF-exit edge
    base = cyc;
    for (int i = 0; i < 5; i++) exp_rise.push_back(base + 1 + 6 * i);
    exp_ovf.push_back(base + 5);
    exp_ovf.push_back(base + 6);
    repeat (7) step(1'b1);
    chk("s4_pend_hold", int'(pending), 3);
    chk("s4_no_ovf", int'(overflow), 0);
    chk("s4_led_next", int'(led_out), 1);
    step(1'b0);
    wait_idle(50);
    chk("s4_end_cycle", cyc, base + 31);
    repeat (2) step(1'b0);

    // Reset mid-blink with pending = 2
    base = cyc;
    exp_rise.push_back(base + 1);
    repeat (3) step(1'b1);
    pulse_in = 1'b0;
    chk("s5_pend_pre", int'(pending), 2);
    #1 rst_a_n = 1'b0;
    #1;
    chk("s5_led_async", int'(led_out), 0);
    chk("s5_busy_async", int'(busy), 0);
    chk("s5_pend_async", int'(pending), 0);
    chk("s5_ovf_async", int'(overflow), 0);
    @(negedge clk);
    @(negedge clk);
    rst_a_n = 1'b1;
    repeat (20) step(1'b0);
    chk("s5_busy_after", int'(busy), 0);
    chk("s5_pend_after", int'(pending), 0);

    // Pulse on the final OFF cycle restarts with no idle gap
    base = cyc;
    exp_rise.push_back(base + 1);
    exp_rise.push_back(base + 7);
    step(1'b1);
    idle_until(base + 6);
    step(1'b1);
    chk("s6_busy", int'(busy), 1);
    chk("s6_led", int'(led_out), 1);
    chk("s6_pending", int'(pending), 0);
    step(1'b0);
    wait_idle(20);
    chk("s6_end_cycle", cyc, base + 13);

    repeat (3) step(1'b0);
    chk("rise_q_left", exp_rise.size(), 0);
    chk("ovf_q_left", exp_ovf.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
